// File: rtl/mem_access_unit.sv
// Load/store unit between a byte-addressed requester and a 24-bit, 3-lane RAM.
// Handles big-endian lane placement, splitting of halves that straddle a word, and load extension.
module mem_access_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [19:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic        rsp_valid,
    output logic [23:0] rsp_rdata,
    output logic        rsp_err,
    output logic [17:0] ram_address,
    output logic [23:0] ram_data,
    output logic        ram_wren,
    output logic [2:0]  ram_byteena,
    input  logic [23:0] ram_q
);

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

    state_t      state;
    logic        we_r;
    logic        signed_r;
    logic        split_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic [17:0] word_r;
    logic [7:0]  lo_r;
    logic [7:0]  hi_r;
    logic [1:0]  wait_cnt;

    logic [1:0]  req_lane;
    logic        req_bad;
    logic        req_split;
    logic [2:0]  first_be;
    logic [23:0] first_data;
    logic [23:0] load_raw;
    logic [23:0] load_result;
    logic        wait_done;

    assign req_lane  = req_addr[1:0];
    assign wait_done = (wait_cnt == 2'(RD_LAT - 1));

    always_comb begin
        req_bad   = (req_lane == 2'd3) || (req_size == 2'd3) ||
                    ((req_size == 2'd2) && (req_lane != 2'd0));
        req_split = (req_size == 2'd1) && (req_lane == 2'd2);
    end

    // First (or only) access: lane 0 is the most significant byte of the RAM word.
    always_comb begin
        first_be   = 3'b111;
        first_data = req_wdata;
        case (req_size)
            2'd0: begin
                case (req_lane)
                    2'd0:    begin first_be = 3'b100; first_data = {req_wdata[7:0], 16'h0000}; end
                    2'd1:    begin first_be = 3'b010; first_data = {8'h00, req_wdata[7:0], 8'h00}; end
                    default: begin first_be = 3'b001; first_data = {16'h0000, req_wdata[7:0]}; end
                endcase
            end
            2'd1: begin
                case (req_lane)
                    2'd0:    begin first_be = 3'b110; first_data = {req_wdata[15:0], 8'h00}; end
                    2'd1:    begin first_be = 3'b011; first_data = {8'h00, req_wdata[15:0]}; end
                    default: begin first_be = 3'b001; first_data = {16'h0000, req_wdata[15:8]}; end
                endcase
            end
            default: begin
                first_be   = 3'b111;
                first_data = req_wdata;
            end
        endcase
        if (!req_we) begin
            first_data = 24'h000000;
        end
    end

    // In WAIT1 the result is the split half: high byte from the first word, low byte from lane 0.
    always_comb begin
        load_raw = 24'h000000;
        if (state == WAIT1) begin
            load_raw = {8'h00, hi_r, ram_q[23:16]};
        end else begin
            case (size_r)
                2'd0: begin
                    case (lane_r)
                        2'd0:    load_raw = {16'h0000, ram_q[23:16]};
                        2'd1:    load_raw = {16'h0000, ram_q[15:8]};
                        default: load_raw = {16'h0000, ram_q[7:0]};
                    endcase
                end
                2'd1:    load_raw = (lane_r == 2'd0) ? {8'h00, ram_q[23:8]} : {8'h00, ram_q[15:0]};
                default: load_raw = ram_q;
            endcase
        end
        case (size_r)
            2'd0:    load_result = signed_r ? {{16{load_raw[7]}}, load_raw[7:0]} : load_raw;
            2'd1:    load_result = signed_r ? {{8{load_raw[15]}}, load_raw[15:0]} : load_raw;
            default: load_result = load_raw;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 24'h000000;
            rsp_err     <= 1'b0;
            ram_address <= 18'h00000;
            ram_data    <= 24'h000000;
            ram_wren    <= 1'b0;
            ram_byteena <= 3'b000;
            we_r        <= 1'b0;
            signed_r    <= 1'b0;
            split_r     <= 1'b0;
            size_r      <= 2'd0;
            lane_r      <= 2'd0;
            word_r      <= 18'h00000;
            lo_r        <= 8'h00;
            hi_r        <= 8'h00;
            wait_cnt    <= 2'd0;
        end else begin
            rsp_valid <= 1'b0;
            ram_wren  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready <= 1'b0;
                        we_r      <= req_we;
                        signed_r  <= req_signed;
                        split_r   <= req_split;
                        size_r    <= req_size;
                        lane_r    <= req_lane;
                        word_r    <= req_addr[19:2];
                        lo_r      <= req_wdata[7:0];
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 24'h000000;
                        end else begin
                            state       <= ISSUE0;
                            ram_address <= req_addr[19:2];
                            ram_byteena <= first_be;
                            ram_data    <= first_data;
                            ram_wren    <= req_we;
                        end
                    end
                end
                ISSUE0: begin
                    if (we_r && split_r) begin
                        state       <= ISSUE1;
                        ram_address <= word_r + 18'd1;
                        ram_byteena <= 3'b100;
                        ram_data    <= {lo_r, 16'h0000};
                        ram_wren    <= 1'b1;
                    end else if (we_r) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 24'h000000;
                    end else begin
                        state    <= WAIT0;
                        wait_cnt <= 2'd0;
                    end
                end
                WAIT0: begin
                    if (!wait_done) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else if (split_r) begin
                        state       <= ISSUE1;
                        hi_r        <= ram_q[7:0];
                        ram_address <= word_r + 18'd1;
                        ram_byteena <= 3'b100;
                        ram_data    <= 24'h000000;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_result;
                    end
                end
                ISSUE1: begin
                    if (we_r) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 24'h000000;
                    end else begin
                        state    <= WAIT1;
                        wait_cnt <= 2'd0;
                    end
                end
                WAIT1: begin
                    if (!wait_done) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_result;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, reset-abort sequences and
// randomized requests checked against a byte-addressed big-endian memory model.
module tb_mem_access_unit;

    localparam int RDL   = 1;
    localparam int TOTAL = 3 * 262144;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [19:0] req_addr = 20'h0;
    logic [23:0] req_wdata = 24'h0;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_err;
    logic [17:0] ram_address;
    logic [23:0] ram_data;
    logic        ram_wren;
    logic [2:0]  ram_byteena;
    logic [23:0] ram_q;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.RD_LAT(RDL)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ram_address(ram_address), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_byteena(ram_byteena), .ram_q(ram_q)
    );

    // RAM model: only the low 6 address bits are decoded, enough for the words the bench uses.
    typedef struct packed {
        logic [17:0] a;
        logic [2:0]  be;
        logic [23:0] d;
    } wr_t;

    logic [23:0] ram [64];
    logic [23:0] rd_pipe0 = 24'h0;
    logic [23:0] rd_pipe1 = 24'h0;
    logic        ram_clear = 1'b1;
    wr_t         wr_log[$];

    function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] d, input logic [2:0] be);
        logic [23:0] r;
        r = old;
        for (int i = 0; i < 3; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < 64; i++) ram[i] <= 24'h0;
        end else if (ram_wren) begin
            ram[ram_address[5:0]] <= merge(ram[ram_address[5:0]], ram_data, ram_byteena);
            wr_log.push_back('{ram_address, ram_byteena, ram_data});
        end
        rd_pipe0 <= ram_clear ? 24'h0 : ram[ram_address[5:0]];
        rd_pipe1 <= rd_pipe0;
    end

    assign ram_q = (RDL == 2) ? rd_pipe1 : rd_pipe0;

    // Reference model: memory is a flat big-endian byte array, byte index = word*3 + lane.
    byte unsigned ref_mem [int];

    task automatic refModel(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [19:0] addr, input logic [23:0] wdata,
                            output logic [23:0] rd, output logic err, output int lat, output int nwr);
        int nbytes, base, naccess;
        logic [23:0] v;
        logic [1:0]  lane;
        lane = addr[1:0];
        err  = (lane == 2'd3) || (size == 2'd3) || (size == 2'd2 && lane != 2'd0);
        rd   = 24'h0;
        lat  = 1;
        nwr  = 0;
        if (!err) begin
            nbytes  = int'(size) + 1;
            base    = int'(addr[19:2]) * 3 + int'(lane);
            naccess = (base / 3 != (base + nbytes - 1) / 3) ? 2 : 1;
            if (we) begin
                for (int i = 0; i < nbytes; i++)
                    ref_mem[(base + i) % TOTAL] = 8'(wdata >> (8 * (nbytes - 1 - i)));
                lat = 1 + naccess;
                nwr = naccess;
            end else begin
                v = 24'h0;
                for (int i = 0; i < nbytes; i++) begin
                    int idx;
                    idx = (base + i) % TOTAL;
                    v = (v << 8) | 24'(ref_mem.exists(idx) ? ref_mem[idx] : 8'h00);
                end
                if (sgn && nbytes < 3 && v[8*nbytes-1]) v = v | (24'hFFFFFF << (8 * nbytes));
                rd  = v;
                lat = (naccess == 2) ? 3 + 2 * RDL : 2 + RDL;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one request, then measures response latency and the cycle after the pulse.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [19:0] addr, input logic [23:0] wdata,
                                 output logic [23:0] rd, output logic err, output int lat,
                                 output logic v_after, output logic rdy_after,
                                 output logic [23:0] rd_after, output logic err_after);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("ready_before_accept", 64'(req_ready), 64'd1);
        wr_log.delete();
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 20'($urandom);
        req_wdata  = 24'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clock);
        #1;
        v_after   = rsp_valid;
        rdy_after = req_ready;
        rd_after  = rsp_rdata;
        err_after = rsp_err;
    endtask

    task automatic runAndCheck(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                               input logic [19:0] addr, input logic [23:0] wdata,
                               input logic [23:0] exp_rd, input logic exp_err, input int exp_lat,
                               input int exp_nwr, input bit chk_wr, input wr_t wr0, input wr_t wr1);
        logic [23:0] rd, rd_after;
        logic err, v_after, rdy_after, err_after;
        int lat;
        applyStimulus(we, size, sgn, addr, wdata, rd, err, lat, v_after, rdy_after, rd_after, err_after);
        checkOutput({tag, " rdata"}, 64'(rd), 64'(exp_rd));
        checkOutput({tag, " err"}, 64'(err), 64'(exp_err));
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " write_count"}, 64'(wr_log.size()), 64'(exp_nwr));
        checkOutput({tag, " valid_pulse"}, 64'(v_after), 64'd0);
        checkOutput({tag, " ready_after"}, 64'(rdy_after), 64'd1);
        checkOutput({tag, " rdata_hold"}, 64'(rd_after), 64'(exp_rd));
        checkOutput({tag, " err_hold"}, 64'(err_after), 64'(exp_err));
        if (chk_wr && exp_nwr > 0 && wr_log.size() > 0) checkOutput({tag, " write0"}, 64'(wr_log[0]), 64'(wr0));
        if (chk_wr && exp_nwr > 1 && wr_log.size() > 1) checkOutput({tag, " write1"}, 64'(wr_log[1]), 64'(wr1));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [19:0] addr;
        logic [23:0] wdata;
        logic [23:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
        wr_t         wr0;
        wr_t         wr1;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic we, input logic [1:0] size, input logic sgn, input logic [19:0] addr,
                          input logic [23:0] wdata, input logic [23:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_nwr, input wr_t wr0, input wr_t wr1);
        vec_t v;
        v = '{we, size, sgn, addr, wdata, exp_rd, exp_err, exp_lat, exp_nwr, wr0, wr1};
        vecs.push_back(v);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        checkOutput({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
        checkOutput({tag, " ram_address"}, 64'(ram_address), 64'd0);
        checkOutput({tag, " ram_data"}, 64'(ram_data), 64'd0);
        checkOutput({tag, " ram_wren"}, 64'(ram_wren), 64'd0);
        checkOutput({tag, " ram_byteena"}, 64'(ram_byteena), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] e_rd;
        logic e_err;
        int e_lat, e_nwr, j;
        logic [17:0] words [7];
        words = '{18'h00000, 18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00005, 18'h3FFFF};

        addVec(1, 2'd0, 0, {18'h00001, 2'd0}, 24'h0000FF, 24'h000000, 0, 2, 1, '{18'h00001, 3'b100, 24'hFF0000}, '0);
        addVec(1, 2'd2, 0, {18'h00004, 2'd0}, 24'hABCDEF, 24'h000000, 0, 2, 1, '{18'h00004, 3'b111, 24'hABCDEF}, '0);
        addVec(0, 2'd0, 1, {18'h00004, 2'd1}, 24'h000000, 24'hFFFFCD, 0, 2 + RDL, 0, '0, '0);
        addVec(0, 2'd0, 0, {18'h00004, 2'd1}, 24'h000000, 24'h0000CD, 0, 2 + RDL, 0, '0, '0);
        addVec(1, 2'd1, 0, {18'h00010, 2'd2}, 24'h001234, 24'h000000, 0, 3, 2,
               '{18'h00010, 3'b001, 24'h000012}, '{18'h00011, 3'b100, 24'h340000});
        addVec(0, 2'd1, 0, {18'h00010, 2'd2}, 24'h000000, 24'h001234, 0, 3 + 2 * RDL, 0, '0, '0);
        addVec(1, 2'd2, 0, {18'h00000, 2'd1}, 24'h777777, 24'h000000, 1, 1, 0, '0, '0);
        addVec(0, 2'd0, 0, {18'h00004, 2'd3}, 24'h000000, 24'h000000, 1, 1, 0, '0, '0);
        addVec(1, 2'd3, 0, {18'h00004, 2'd0}, 24'h123456, 24'h000000, 1, 1, 0, '0, '0);
        addVec(1, 2'd1, 0, {18'h3FFFF, 2'd2}, 24'h008081, 24'h000000, 0, 3, 2,
               '{18'h3FFFF, 3'b001, 24'h000080}, '{18'h00000, 3'b100, 24'h810000});
        addVec(0, 2'd1, 1, {18'h3FFFF, 2'd2}, 24'h000000, 24'hFF8081, 0, 3 + 2 * RDL, 0, '0, '0);
        addVec(0, 2'd2, 1, {18'h00004, 2'd0}, 24'h000000, 24'hABCDEF, 0, 2 + RDL, 0, '0, '0);
        addVec(0, 2'd1, 1, {18'h00004, 2'd0}, 24'h000000, 24'hFFABCD, 0, 2 + RDL, 0, '0, '0);
        addVec(0, 2'd1, 0, {18'h00004, 2'd1}, 24'h000000, 24'h00CDEF, 0, 2 + RDL, 0, '0, '0);
        addVec(0, 2'd0, 0, {18'h00001, 2'd0}, 24'h000000, 24'h0000FF, 0, 2 + RDL, 0, '0, '0);
        addVec(0, 2'd0, 1, {18'h00000, 2'd0}, 24'h000000, 24'hFFFF81, 0, 2 + RDL, 0, '0, '0);

        // Power-on reset: outputs held at zero across clock edges.
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkAllZero("reset");
        @(negedge clock);
        ram_clear = 1'b0;
        reset     = 1'b0;
        #1;
        checkOutput("ready_low_before_edge", 64'(req_ready), 64'd0);
        @(posedge clock);
        #1;
        checkOutput("ready_first_edge", 64'(req_ready), 64'd1);

        foreach (vecs[i]) begin
            refModel(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, e_rd, e_err, e_lat, e_nwr);
            runAndCheck($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                        vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_nwr,
                        1'b1, vecs[i].wr0, vecs[i].wr1);
        end

        // Reset during WAIT0 of a load: immediate clear, no response, ready one edge after release.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = {18'h00004, 2'd0};
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1 checkAllZero("abort_load");
        repeat (2) @(posedge clock);
        #1 checkOutput("abort_load no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 checkOutput("abort_load ready_low", 64'(req_ready), 64'd0);
        @(posedge clock);
        #1 checkOutput("abort_load ready_back", 64'(req_ready), 64'd1);
        checkOutput("abort_load still_no_rsp", 64'(rsp_valid), 64'd0);

        // Reset during ISSUE0 of a store: write enable drops asynchronously, store never lands.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = {18'h00005, 2'd0}; req_wdata = 24'h123456;
        @(posedge clock);
        #1 req_valid = 1'b0;
        checkOutput("abort_store wren_high", 64'(ram_wren), 64'd1);
        #2 reset = 1'b1;
        #1 checkOutput("abort_store wren_cleared", 64'(ram_wren), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        refModel(0, 2'd2, 0, {18'h00005, 2'd0}, 24'h0, e_rd, e_err, e_lat, e_nwr);
        runAndCheck("abort_store readback", 0, 2'd2, 0, {18'h00005, 2'd0}, 24'h0, e_rd, e_err, e_lat, e_nwr, 1'b0, '0, '0);

        // Randomized requests against the byte-array model.
        for (int n = 0; n < 150; n++) begin
            logic        r_we, r_sgn;
            logic [1:0]  r_size, r_lane;
            logic [19:0] r_addr;
            logic [23:0] r_wdata;
            r_we    = 1'($urandom);
            r_sgn   = 1'($urandom);
            r_size  = 2'($urandom_range(0, 3));
            r_lane  = 2'($urandom_range(0, 3));
            j       = int'($urandom_range(0, 6));
            r_addr  = {words[j], r_lane};
            r_wdata = 24'($urandom);
            refModel(r_we, r_size, r_sgn, r_addr, r_wdata, e_rd, e_err, e_lat, e_nwr);
            runAndCheck($sformatf("rand%0d", n), r_we, r_size, r_sgn, r_addr, r_wdata,
                        e_rd, e_err, e_lat, e_nwr, 1'b0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter RD_LAT, default 1, meaning: RAM read latency in clock cycles from address presented to ram_q valid; legal values 1 and 2.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester has a memory request.
REQ-005 req_ready  output  1  unit accepts a request; a transfer occurs when req_valid and req_ready are both high on a rising edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 = byte, 01 = half (2 bytes), 10 = word (3 bytes), 11 = reserved.
REQ-008 req_signed  input  1  sign-extend load result when 1, zero-extend when 0.
REQ-009 req_addr  input  20  byte address: [19:2] = word index, [1:0] = lane (0..2).
REQ-010 req_wdata  input  24  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle pulse marking request completion; no response backpressure.
REQ-012 rsp_rdata  output  24  load result, right-justified and extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  request rejected; valid only while rsp_valid is high.
REQ-014 ram_address  output  18  to Ram address.
REQ-015 ram_data  output  24  to Ram data.
REQ-016 ram_wren  output  1  to Ram wren.
REQ-017 ram_byteena  output  3  to Ram byteena.
REQ-018 ram_q  input  24  from Ram q.

Function
REQ-019 Lane mapping: lane 0 -> bits 23:16 / byteena[2]; lane 1 -> bits 15:8 / byteena[1]; lane 2 -> bits 7:0 / byteena[0].
REQ-020 Multi-byte data is big-endian: the lower lane holds the more significant byte.
REQ-021 req_ready is high only in IDLE; a request is captured in full on acceptance, and later input changes have no effect.
REQ-022 FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP. Transitions:
- IDLE -> ISSUE0 on accept.
- ISSUE0 -> WAIT0 for a load; ISSUE0 -> ISSUE1 (split) or RESP for a store.
- WAIT0 -> ISSUE1 (split) or RESP after RD_LAT cycles.
- ISSUE1 -> WAIT1 for a load; ISSUE1 -> RESP for a store.
- WAIT1 -> RESP after RD_LAT cycles.
- RESP -> IDLE.
REQ-023 Error cases: lane 3, req_size 11, or a word request with lane != 0. Each goes IDLE -> RESP with rsp_err=1 and no RAM access (ram_wren stays 0).
REQ-024 Split case: a half request at lane 2 is split into two accesses.
- First access: word W, byteena 001, high byte.
- Second access: word W+1, byteena 100, low byte.
- Word index wraps 3FFFF -> 00000.
REQ-025 Non-split byteena: byte = one lane bit; half at lane 0 -> 110; half at lane 1 -> 011; word -> 111.
REQ-026 Store data is shifted so that each byte sits in its enabled lane; disabled lanes drive 0.
REQ-027 ram_wren is high for exactly one cycle per store access (in ISSUE0/ISSUE1) and is 0 in every other state.
REQ-028 Load data capture: ram_address is held from ISSUEn through WAITn, and ram_q is sampled on the final WAITn edge. The two split bytes are concatenated high:low.
REQ-029 Latency, with acceptance at edge T, measured as rsp_valid high in cycle T+n:
- Single store: n = 2.
- Single load: n = 2+RD_LAT.
- Split store: n = 3.
- Split load: n = 3+2*RD_LAT.
- Error: n = 1.
REQ-030 Load extension: byte -> 8 bits, half -> 16 bits, extended to 24 per req_signed; a word load is returned as-is.
REQ-031 rsp_valid is asserted only in RESP; rsp_rdata and rsp_err hold their values until the next RESP.
REQ-032 A new request may be accepted in the cycle following RESP (back-to-back; one idle cycle per request).

Reset
REQ-033 While reset is high, all of the following are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, ram_address, ram_data, ram_wren, ram_byteena; the FSM is in IDLE.
REQ-034 req_ready rises on the first rising edge after reset deasserts.
REQ-035 Reset asserted mid-operation aborts the request immediately.
- No response is issued for the aborted request.
- A store access in progress has ram_wren cleared asynchronously.

Verification
REQ-036 Store byte 0xFF at addr {18'h00001,2'd0} -> ram_wren one cycle, address 00001, byteena 100, data FF0000; rsp_valid at T+2, rsp_err 0.
REQ-037 Word 0xABCDEF stored at word 4, then signed and unsigned byte loads at lane 1 -> rsp_rdata FFFFCD (signed) and 0000CD (unsigned); rsp_valid at T+3 with RD_LAT=1.
REQ-038 Half store 0x1234 at {18'h00010,2'd2} -> two writes: (00010, 001, 000012), then (00011, 100, 340000). Half load of the same address -> 001234 at T+5.
REQ-039 Word request at lane 1, and any request with lane 3 -> rsp_valid at T+1, rsp_err 1, no ram_wren.
REQ-040 Split half store at word 3FFFF lane 2 -> second write at address 00000, byteena 100.
REQ-041 Reset asserted during WAIT0 of a load -> outputs 0 immediately, no rsp_valid; req_ready returns one edge after reset deasserts.
